// File: rtl/waveform_pkg.sv
// Shared definitions for the waveform generation / measurement path.
package waveform_pkg;

  typedef enum logic [1:0] {
    SEEK_LOW  = 2'd0,
    SEEK_HIGH = 2'd1,
    RUN_LOW   = 2'd2,
    RUN_HIGH  = 2'd3
  } meter_state_t;

  localparam int unsigned SAMPLE_W_DEFAULT = 10;
  localparam int unsigned MID = 1 << (SAMPLE_W_DEFAULT - 1);

  localparam int unsigned AVG_DEPTH = 4;
  localparam int unsigned AVG_LOG2  = 2;

  // Midscale of an offset-binary sample of the given width.
  function automatic int unsigned mid_of(input int unsigned sample_w);
    return 32'd1 << (sample_w - 1);
  endfunction

endpackage

// File: rtl/period_avg4.sv
// Running mean of the last AVG_DEPTH measured periods; valid only once the
// window is full after a flush.
module period_avg4
  import waveform_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                strobe,
  input  logic [PERIOD_W-1:0] period,
  output logic [PERIOD_W-1:0] avg,
  output logic                avg_valid,
  output logic                primed_c
);

  localparam int unsigned SUM_W  = PERIOD_W + AVG_LOG2;
  localparam int unsigned FILL_W = AVG_LOG2 + 1;
  localparam int unsigned HIST_N = AVG_DEPTH - 1;

  logic [PERIOD_W-1:0] hist_q [HIST_N];
  logic [FILL_W-1:0]   fill_q;
  logic [SUM_W-1:0]    sum_c;

  // Window sum including the incoming period.
  always_comb begin
    sum_c = SUM_W'(period);
    for (int i = 0; i < int'(HIST_N); i++) begin
      sum_c = sum_c + SUM_W'(hist_q[i]);
    end
  end

  assign primed_c = (fill_q >= FILL_W'(HIST_N));

  always_ff @(posedge clock) begin
    if (!reset) begin
      avg       <= '0;
      avg_valid <= 1'b0;
      fill_q    <= '0;
      for (int i = 0; i < int'(HIST_N); i++) hist_q[i] <= '0;
    end else if (flush) begin
      avg_valid <= 1'b0;
      fill_q    <= '0;
      for (int i = 0; i < int'(HIST_N); i++) hist_q[i] <= '0;
    end else begin
      avg_valid <= 1'b0;
      if (strobe) begin
        hist_q[0] <= period;
        for (int i = 1; i < int'(HIST_N); i++) hist_q[i] <= hist_q[i-1];
        if (fill_q != FILL_W'(AVG_DEPTH)) fill_q <= fill_q + FILL_W'(1);
        if (primed_c) begin
          avg       <= PERIOD_W'(sum_c >> AVG_LOG2);
          avg_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/waveform_period_meter.sv
// Measures waveform period as valid samples between rising midscale crossings.
// Define PERIOD_METER_AVG_EN to report the mean of the last four periods.
module waveform_period_meter
  import waveform_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 10,
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned HYST       = 16,
  parameter int unsigned MAX_PERIOD = 4095
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid,
  output logic                locked,
  output logic                timeout
);

  localparam int unsigned MID_V = mid_of(SAMPLE_W);
  localparam logic [SAMPLE_W-1:0] LO = SAMPLE_W'(MID_V - HYST);
  localparam logic [SAMPLE_W-1:0] HI = SAMPLE_W'(MID_V + HYST);
  localparam logic [PERIOD_W-1:0] CNT_MAX = PERIOD_W'(MAX_PERIOD);

  meter_state_t        state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                locked_q, locked_d;
  logic                timeout_q, timeout_d;
  logic                is_low_c, is_high_c, accept_c, running_c;
  logic                first_c, crossing_c, expire_c, lock_set_c;

  assign is_low_c   = (sample_in <= LO);
  assign is_high_c  = (sample_in >= HI);
  assign accept_c   = sample_valid & ~clear;
  assign running_c  = (state_q == RUN_LOW) || (state_q == RUN_HIGH);
  assign first_c    = accept_c & (state_q == SEEK_HIGH) & is_high_c;
  assign crossing_c = accept_c & (state_q == RUN_HIGH) & is_high_c;
  assign expire_c   = accept_c & running_c & ~crossing_c & (cnt_q == CNT_MAX);

  always_ff @(posedge clock) begin
    if (!reset) state_q <= SEEK_LOW;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear || expire_c) begin
      state_d = SEEK_LOW;
    end else if (sample_valid) begin
      case (state_q)
        SEEK_LOW:  if (is_low_c)  state_d = SEEK_HIGH;
        SEEK_HIGH: if (is_high_c) state_d = RUN_LOW;
        RUN_LOW:   if (is_low_c)  state_d = RUN_HIGH;
        RUN_HIGH:  if (is_high_c) state_d = RUN_LOW;
        default:                  state_d = SEEK_LOW;
      endcase
    end
  end

  // Counter, lock and timeout next values; a crossing restarts the count at 1.
  always_comb begin
    cnt_d     = cnt_q;
    locked_d  = locked_q;
    timeout_d = expire_c;
    if (clear) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (first_c || crossing_c) begin
      cnt_d = PERIOD_W'(1);
      if (lock_set_c) locked_d = 1'b1;
    end else if (expire_c) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (accept_c && running_c) begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q     <= '0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign locked  = locked_q;
  assign timeout = timeout_q;

`ifdef PERIOD_METER_AVG_EN
  logic primed_c;

  period_avg4 #(.PERIOD_W(PERIOD_W)) u_avg (
    .clock     (clock),
    .reset     (reset),
    .flush     (clear | expire_c),
    .strobe    (crossing_c),
    .period    (cnt_q),
    .avg       (period_out),
    .avg_valid (period_valid),
    .primed_c  (primed_c)
  );

  assign lock_set_c = crossing_c & primed_c;
`else
  logic [PERIOD_W-1:0] period_q;
  logic                period_valid_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      period_valid_q <= crossing_c;
      if (crossing_c) period_q <= cnt_q;
    end
  end

  assign lock_set_c   = crossing_c;
  assign period_out   = period_q;
  assign period_valid = period_valid_q;
`endif

endmodule

// File: tb/tb_waveform_period_meter.sv
// Randomized and directed bench for waveform_period_meter with a behavioural
// crossing/period model and literal anchor checks.
module tb_waveform_period_meter;

  localparam int MAXP = 4095;
  localparam int LO   = 512 - 16;
  localparam int HI   = 512 + 16;
`ifdef PERIOD_METER_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        sample_valid = 1'b0;
  logic [9:0]  sample_in = '0;
  logic [15:0] period_out;
  logic        period_valid, locked, timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ph      = 0;
  bit cmp_en  = 1'b0;

  always #5 clock = ~clock;

  waveform_period_meter #(
    .SAMPLE_W(10), .PERIOD_W(16), .HYST(16), .MAX_PERIOD(4095)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  // Behavioural model: reference crossing seen, low seen since reference,
  // samples since reference, and a list of recent periods.
  bit m_have, m_seen_low, m_armed, m_locked, m_pv, m_to;
  int m_n, m_period;
  int hist[$];

  task automatic record_period(input int p);
    if (AVG) begin
      hist.push_back(p);
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4) begin
        m_period = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
        m_pv = 1'b1;
        m_locked = 1'b1;
      end
    end else begin
      m_period = p;
      m_pv = 1'b1;
      m_locked = 1'b1;
    end
  endtask

  always @(posedge clock) begin
    bit lo, hi;
    lo = (int'(sample_in) <= LO);
    hi = (int'(sample_in) >= HI);
    m_pv = 1'b0;
    m_to = 1'b0;
    if (!reset) begin
      m_have = 0; m_seen_low = 0; m_armed = 0; m_locked = 0; m_n = 0; m_period = 0;
      hist.delete();
    end else if (clear) begin
      m_have = 0; m_seen_low = 0; m_armed = 0; m_locked = 0; m_n = 0;
      hist.delete();
    end else if (sample_valid) begin
      if (!m_have) begin
        if (!m_seen_low) m_seen_low = lo;
        else if (hi) begin m_have = 1; m_armed = 0; m_n = 1; end
      end else if (m_armed && hi) begin
        record_period(m_n);
        m_n = 1;
        m_armed = 0;
      end else if (m_n == MAXP) begin
        m_to = 1; m_have = 0; m_seen_low = 0; m_armed = 0; m_locked = 0; m_n = 0;
        hist.delete();
      end else begin
        m_n++;
        if (lo) m_armed = 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      check("period_out", 32'(period_out), 32'(m_period));
      check("period_valid", 32'(period_valid), 32'(m_pv));
      check("locked", 32'(locked), 32'(m_locked));
      check("timeout", 32'(timeout), 32'(m_to));
    end
  end

  task automatic drive(input logic v, input logic [9:0] s, input logic clr);
    sample_valid = v;
    sample_in    = s;
    clear        = clr;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic int tri_val(input int i);
    int p;
    p = i % 40;
    return (p < 20) ? (p * 1023 / 20) : ((40 - p) * 1023 / 20);
  endfunction

  // Triangle of period 40 samples, one valid sample every gap clocks.
  task automatic run_wave(input string tag, input int n, input int gap, input int jit,
                          input int exp_p, input int exp_pulses);
    int pulses, last, v;
    pulses = 0;
    last = -1;
    for (int k = 0; k < n; k++) begin
      for (int g = 1; g < gap; g++) drive(1'b0, 10'($urandom_range(1023)), 1'b0);
      v = tri_val(ph);
      if (jit > 0) v = v + int'($urandom_range(2 * jit)) - jit;
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      ph++;
      drive(1'b1, 10'(v), 1'b0);
      if (period_valid === 1'b1) begin
        pulses++;
        if (exp_p > 0) begin
          check({tag, "_period"}, 32'(period_out), 32'(exp_p));
          if (last >= 0) check({tag, "_spacing"}, 32'(cyc - last), 32'(40 * gap));
          last = cyc;
        end
      end
    end
    if (exp_pulses >= 0) check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
  endtask

  initial begin
    int k, pulses, idx;
    bit seen;
    int plist[4];
    int want[$];
    int got[$];
    logic [9:0] s;

    // Reset held with random inputs.
    reset = 1'b0;
    drive(1'($urandom_range(1)), 10'($urandom_range(1023)), 1'($urandom_range(1)));
    cmp_en = 1'b1;
    drive(1'($urandom_range(1)), 10'($urandom_range(1023)), 1'($urandom_range(1)));
    check("rst_period_out", 32'(period_out), 0);
    check("rst_period_valid", 32'(period_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_timeout", 32'(timeout), 0);

    // Midscale constant: nothing may pulse.
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 10'd512, 1'b0);
      if (period_valid === 1'b1 || timeout === 1'b1) pulses++;
    end
    check("idle_pulses", 32'(pulses), 0);

    ph = 0;
    run_wave("lock_a", 52, 1, 0, 40, AVG ? 0 : 1);
    check("lock_after_second_crossing", 32'(locked), AVG ? 0 : 1);
    run_wave("lock_b", 148, 1, 0, 40, AVG ? 1 : 3);
    check("lock_locked", 32'(locked), 1);
    run_wave("gapped", 200, 3, 0, 40, 5);
    run_wave("noise15", 240, 1, 15, 40, 6);
    run_wave("noise20", 400, 1, 20, 0, -1);

    // Timeout after the last crossing.
    drive(1'b1, 10'd0, 1'b1);
    ph = 0;
    run_wave("pre_to", 132, 1, 0, 40, AVG ? 0 : 3);
    k = 0;
    seen = 0;
    while (!seen && k < 5000) begin
      drive(1'b1, 10'd512, 1'b0);
      k++;
      if (timeout === 1'b1) seen = 1;
    end
    check("timeout_sample_index", 32'(k), 32'(MAXP));
    check("timeout_unlock", 32'(locked), 0);
    drive(1'b1, 10'd512, 1'b0);
    check("timeout_width", 32'(timeout), 0);
    ph = 0;
    run_wave("relock", 240, 1, 0, 40, AVG ? 2 : 5);
    check("relock_locked", 32'(locked), 1);

    // Clear with a would-be crossing in the same cycle.
    drive(1'b1, 10'd1023, 1'b1);
    check("clear_locked", 32'(locked), 0);
    check("clear_no_pulse", 32'(period_valid), 0);
    check("clear_period_held", 32'(period_out), 40);

    // Periods 40,40,44,44.
    plist = '{40, 40, 44, 44};
    if (AVG) want = '{42};
    else     want = '{40, 40, 44, 44};
    drive(1'b1, 10'd0, 1'b0);
    drive(1'b1, 10'd1023, 1'b0);
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 10'd0, 1'b0);
      for (int m = 0; m < plist[j] - 2; m++) drive(1'b1, 10'd512, 1'b0);
      drive(1'b1, 10'd1023, 1'b0);
      if (period_valid === 1'b1) got.push_back(int'(period_out));
    end
    check("seq_pulse_count", 32'(got.size()), 32'(want.size()));
    for (int j = 0; j < want.size() && j < got.size(); j++)
      check("seq_period", 32'(got[j]), 32'(want[j]));
    check("seq_locked", 32'(locked), 1);

    // Random soak around the thresholds.
    for (int i = 0; i < 3000; i++) begin
      idx = int'($urandom_range(9));
      case (idx)
        0: s = 10'(LO - 1);
        1: s = 10'(LO);
        2: s = 10'(LO + 1);
        3: s = 10'(HI - 1);
        4: s = 10'(HI);
        5: s = 10'(HI + 1);
        default: s = 10'($urandom_range(1023));
      endcase
      reset = ($urandom_range(999) != 0);
      drive($urandom_range(3) != 0, s, $urandom_range(199) == 0);
    end
    reset = 1'b1;
    drive(1'b0, 10'd0, 1'b0);
    drive(1'b0, 10'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/waveform_period_meter.md
# waveform_period_meter

Measures the period of a sampled periodic waveform, such as the 10-bit output of the sine generator, by counting valid samples between successive rising midscale crossings. Hysteresis rejects noise near midscale. It closes the loop on the waveform-generation path: the generator turns `period` into samples, and this block turns samples back into a period for self-check and lock monitoring.

## Interface
Parameters:
- `SAMPLE_W`, default 10: sample width, offset-binary, with midscale at 2^(SAMPLE_W-1).
- `PERIOD_W`, default 16: width of the counter and of `period_out`.
- `HYST`, default 16: hysteresis half-width. LO = MID-HYST, HI = MID+HYST.
- `MAX_PERIOD`, default 4095: timeout limit in valid samples. Must be less than 2^PERIOD_W.

Ports:
- `clock`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-low. Reset acts when `reset`=0 at a rising edge.
- `clear`, input, 1: synchronous restart of measurement. Active-high.
- `sample_in`, input, SAMPLE_W: waveform sample.
- `sample_valid`, input, 1: `sample_in` is accepted this cycle.
- `period_out`, output, PERIOD_W: last measured period in samples. Registered.
- `period_valid`, output, 1: one-cycle pulse when `period_out` updates.
- `locked`, output, 1: at least one valid period has been measured since the last restart.
- `timeout`, output, 1: one-cycle pulse when MAX_PERIOD is exceeded.

## Operation
- Definitions: low = `sample_in` <= LO; high = `sample_in` >= HI. Unsigned compare.
- Only cycles with `sample_valid`=1 advance the FSM or the counter. Idle cycles hold all state.
- FSM states and transitions:
  - SEEK_LOW: on low → SEEK_HIGH.
  - SEEK_HIGH: on high (first crossing) → RUN_LOW, with cnt=1.
  - RUN_LOW: cnt increments. On low → RUN_HIGH.
  - RUN_HIGH: on high (crossing) → `period_out`=cnt, pulse `period_valid`, set `locked`, cnt=1, go to RUN_LOW. Otherwise cnt increments.
- Timeout: in RUN_LOW or RUN_HIGH, a non-crossing valid sample with cnt == MAX_PERIOD causes:
  - a `timeout` pulse;
  - `locked`=0, cnt=0;
  - return to SEEK_LOW.
- A crossing at cnt == MAX_PERIOD reports MAX_PERIOD. The crossing wins over the timeout.
- `clear`=1 causes SEEK_LOW, cnt=0, `locked`=0, and no pulses. `period_out` holds its value. `clear` has priority over `sample_valid` in the same cycle.
- The counter never wraps, because the timeout fires first.

## Timing
- All outputs are registered.
- `period_valid` and `timeout` assert on the clock edge that accepts the crossing or timeout sample. They are visible the following cycle and stay high for exactly one cycle.
- `locked` rises in the same cycle as the first `period_valid`.
- Reset values: `period_out`=0, `period_valid`=0, `locked`=0, `timeout`=0, FSM=SEEK_LOW, cnt=0.
- Reset mid-operation aborts measurement immediately and takes priority over `clear`.
- Back-to-back `sample_valid` is supported. Arbitrary gaps between valid samples are supported.

## Configuration
- `PERIOD_METER_AVG_EN` defined:
  - `period_out` is the mean of the last 4 measured periods: a 4-entry history, sum of PERIOD_W+2 bits, right-shifted by 2 with truncation.
  - `period_valid` and `locked` first assert at the 4th measurement after a restart.
  - The history is flushed by reset, `clear` and timeout.
- Undefined: `period_out` is the raw latest period, and there is no history storage.

## Structure
- Shared package `waveform_pkg` holds:
  - the FSM state encoding (SEEK_LOW, SEEK_HIGH, RUN_LOW, RUN_HIGH);
  - the MID constant;
  - the AVG depth and log2 (4 and 2).
- Sub-module `period_avg4`, instantiated only under `PERIOD_METER_AVG_EN`. It contains the history, adder and fill counter. It takes a period strobe and a flush input, and outputs the average plus a valid signal.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with random inputs → all outputs 0. After release with a constant 512 input, nothing pulses for 100 samples.
- Lock: triangle wave 0→1023→0 with a period of 40 samples, `sample_valid`=1 every cycle → `period_out`=40 with a `period_valid` pulse every 40 samples. `locked`=1 after the second rising crossing.
- Gapped input: the same triangle with `sample_valid` every 3rd clock → `period_out`=40. The pulse spacing is 120 clocks.
- Noise rejection: ramp through midscale with ±15 LSB jitter (HYST=16) → no extra crossings and the period is unchanged. With ±20 jitter, the reported periods drop, which confirms the hysteresis bound.
- Timeout: after lock, hold `sample_in`=512 → `timeout` pulses on the 4095th non-crossing sample counted since the last crossing. Then `locked`=0. The triangle then re-locks to 40.
- Clear and averaging: `clear` mid-RUN → `locked`=0, `period_out` held. With `PERIOD_METER_AVG_EN`, periods of 40,40,44,44 → the first `period_valid` carries 42.
